// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants for the round pipeline blocks.
package aes_pkg;

  localparam int NB = 4;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

endpackage

// File: rtl/ark_column.sv
// One 32-bit state column of AddRoundKey: column XOR plus, when
// ADD_ROUND_KEY_PARITY_EN is defined, per-byte even parity of the result.
module ark_column
  import aes_pkg::*;
(
  input  word_t      data,
  input  word_t      key,
`ifdef ADD_ROUND_KEY_PARITY_EN
  output logic [3:0] parity,
`endif
  output word_t      out
);

  assign out = data ^ key;

`ifdef ADD_ROUND_KEY_PARITY_EN
  // parity[3] belongs to the most significant byte, matching state byte order
  always_comb begin
    parity = '0;
    for (int b = 0; b < 4; b++) begin
      parity[3-b] = ^out[31-8*b -: 8];
    end
  end
`endif

endmodule

// File: rtl/add_round_key.sv
// AES AddRoundKey: combinational data ^ key plus a registered copy with valid.
// Optional per-byte parity of the registered result: ADD_ROUND_KEY_PARITY_EN.
module add_round_key
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic [127:0] out_reg,
`ifdef ADD_ROUND_KEY_PARITY_EN
  output logic [15:0]  out_parity,
`endif
  output logic         out_valid
);

  // Handshake: in_valid qualifies data/key for one cycle; there is no ready,
  // so every accepted pair yields out_valid exactly one cycle later.

  state_t xor_res;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [15:0] par_res;
`endif

  // NB is only meaningful at 4; the column slicing below assumes 128 bits.
  for (genvar c = 0; c < NB; c++) begin : g_col
    ark_column u_col (
      .data   (data[127-32*c -: 32]),
      .key    (key[127-32*c -: 32]),
`ifdef ADD_ROUND_KEY_PARITY_EN
      .parity (par_res[15-4*c -: 4]),
`endif
      .out    (xor_res[127-32*c -: 32])
    );
  end

  assign out = xor_res;

  // The result register loads only on in_valid, so X operands on idle
  // cycles never reach out_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg    <= '0;
      out_valid  <= 1'b0;
`ifdef ADD_ROUND_KEY_PARITY_EN
      out_parity <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_reg    <= xor_res;
`ifdef ADD_ROUND_KEY_PARITY_EN
        out_parity <= par_res;
`endif
      end
    end
  end

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key: directed vectors, reset, hold,
// random streaming against a queue-based reference model.
module tb_add_round_key;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] data;
  logic [127:0] key;
  logic [127:0] out;
  logic [127:0] out_reg;
  logic         out_valid;
`ifdef ADD_ROUND_KEY_PARITY_EN
  logic [15:0]  out_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_reg;
  logic         exp_valid;

  always #5 clk = ~clk;

  add_round_key #(.NB(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .data       (data),
    .key        (key),
    .out        (out),
    .out_reg    (out_reg),
`ifdef ADD_ROUND_KEY_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_valid  (out_valid)
  );

  // Byte i of the state sits at bits [127-8i -: 8]; parity bit 15-i is its even parity.
  function automatic logic [15:0] parity_of(input logic [127:0] s);
    logic [15:0] p;
    logic [7:0]  b;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[8*(15-i) +: 8];
      p[15-i] = ($countones(b) % 2) == 1;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply operands after the active edge; check the combinational output.
  task automatic drive(input logic [127:0] d, input logic [127:0] k,
                       input logic v, input logic r);
    data     = d;
    key      = k;
    in_valid = v;
    rst      = r;
    #1;
    if (!$isunknown(d) && !$isunknown(k)) chk("out", out, d ^ k);
  endtask

  // Advance one clock, update the model from the sampled controls, check registers.
  task automatic tick();
    logic r, v;
    r = rst;
    v = in_valid;
    if (!r && v) exp_q.push_back(data ^ key);
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      exp_reg   = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_reg   = exp_q.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    chk("out_reg", out_reg, exp_reg);
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
`ifdef ADD_ROUND_KEY_PARITY_EN
    chk("out_parity", {112'd0, out_parity}, {112'd0, parity_of(exp_reg)});
`endif
  endtask

  initial begin
    logic [127:0] fips_d, fips_k, fips_o, ones, d, k;
    fips_d = 128'h046681e5e0cb199a48f8d37a2806264c;
    fips_k = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_o = 128'ha49c7ff2689f352b6b5bea43026a5049;
    ones   = '1;
    exp_reg   = '0;
    exp_valid = 1'b0;

    // clock/reset
    drive('0, '0, 1'b0, 1'b1);
    tick();
    tick();

    // FIPS-197 round-1 vector
    drive(fips_d, fips_k, 1'b1, 1'b0);
    chk("fips_out", out, fips_o);
    tick();
    chk("fips_out_reg", out_reg, fips_o);

    // zero / all-ones operands
    drive('0, '0, 1'b1, 1'b0);
    chk("zero_out", out, '0);
    tick();
    drive(ones, '0, 1'b1, 1'b0);
    chk("ones_out", out, ones);
    tick();
    drive(ones, ones, 1'b1, 1'b0);
    chk("cancel_out", out, '0);
    tick();

    // reset overrides in_valid mid-stream
    drive(fips_d, fips_k, 1'b1, 1'b0);
    tick();
    drive(fips_d, ~fips_k, 1'b1, 1'b1);
    tick();
    drive(fips_k, fips_d, 1'b1, 1'b0);
    tick();

    // hold: in_valid low keeps out_reg, out tracks inputs, X operands ignored
    drive(fips_d, fips_k, 1'b1, 1'b0);
    tick();
    drive(~fips_d, fips_k, 1'b0, 1'b0);
    tick();
    drive('x, 'x, 1'b0, 1'b0);
    tick();
    chk("hold_out_reg", out_reg, fips_o);

    // random back-to-back streaming
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      drive(d, k, 1'b1, 1'b0);
      tick();
    end
    drive('0, '0, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
